// File: rtl/sdram_cmd_gen.sv
// sdram_cmd_gen: registered SDRAM command/pin driver with burst counting, BST issue and data enables.
// Define SDRAM_AUTO_PRE_EN to add write recovery, automatic bank precharge and tRP wait after each burst.
module sdram_cmd_gen #(
    parameter int BA_W    = 2,
    parameter int ROW_W   = 11,
    parameter int COL_W   = 8,
    parameter int CAS_LAT = 3,
    parameter int T_WR    = 2,
    parameter int T_RP    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_valid,
    input  logic [2:0]                  op_code,
    input  logic [BA_W+ROW_W+COL_W-1:0] op_addr,
    input  logic [COL_W:0]              op_len,
    output logic                        op_ready,
    output logic                        sdram_cke,
    output logic                        sdram_cs_n,
    output logic                        sdram_ras_n,
    output logic                        sdram_cas_n,
    output logic                        sdram_we_n,
    output logic [BA_W-1:0]             sdram_ba,
    output logic [ROW_W-1:0]            sdram_addr,
    output logic                        wr_data_en,
    output logic                        rd_data_en
);
    localparam int CNT_W = COL_W + 1;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000, C_BST = 4'b0110;
`ifdef SDRAM_AUTO_PRE_EN
    localparam int WT_MAX = (T_WR > T_RP) ? T_WR : T_RP;
    localparam int WT_W = $clog2(WT_MAX + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_BURST
`ifdef SDRAM_AUTO_PRE_EN
        , S_TWR, S_APRE, S_TRP
`endif
    } state_t;

    state_t             r_state, w_state;
    logic               r_cke;
    logic [3:0]         r_cmd, w_cmd;
    logic [BA_W-1:0]    r_ba, w_ba;
    logic [ROW_W-1:0]   r_addr, w_addr;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_wr, w_wr, r_full, w_full;
    logic [CAS_LAT-1:0] r_rd_sr;
`ifdef SDRAM_AUTO_PRE_EN
    logic [WT_W-1:0]    r_wait, w_wait;
    logic [BA_W-1:0]    r_bank, w_bank_q;
`endif

    logic               w_acc, w_xfer;
    logic [BA_W-1:0]    w_bank;
    logic [ROW_W-1:0]   w_row, w_col_addr, w_lmr;
    logic [COL_W-1:0]   w_col;
    logic [CNT_W-1:0]   w_len;

    assign w_acc  = op_valid && op_ready;
    assign w_bank = op_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
    assign w_row  = op_addr[ROW_W+COL_W-1 -: ROW_W];
    assign w_col  = op_addr[COL_W-1:0];
    assign w_len  = (op_len == '0) ? CNT_W'(1) : op_len;
    assign w_lmr  = ROW_W'({3'(CAS_LAT), 4'b0111});
    assign w_xfer = (r_state == S_BURST) && (r_cnt != '0);

    // A10 must stay low on RD/WR so the device never auto-precharges on its own
    always_comb begin
        w_col_addr     = ROW_W'(w_col);
        w_col_addr[10] = 1'b0;
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_wr    = r_wr;
        w_full  = r_full;
        w_cmd   = C_NOP;
        w_ba    = '1;
        w_addr  = '1;
`ifdef SDRAM_AUTO_PRE_EN
        w_wait   = r_wait;
        w_bank_q = r_bank;
`endif
        case (r_state)
            S_IDLE: if (w_acc) begin
                case (op_code)
                    3'd1: w_cmd = C_PRE;
                    3'd2: w_cmd = C_REF;
                    3'd3: begin
                        w_cmd  = C_LMR;
                        w_ba   = '0;
                        w_addr = w_lmr;
                    end
                    3'd4: begin
                        w_cmd  = C_ACT;
                        w_ba   = w_bank;
                        w_addr = w_row;
                    end
                    3'd5, 3'd6: begin
                        w_cmd   = op_code[0] ? C_RD : C_WR;
                        w_ba    = w_bank;
                        w_addr  = w_col_addr;
                        w_state = S_BURST;
                        w_cnt   = w_len;
                        w_wr    = !op_code[0];
                        w_full  = op_len[COL_W];
`ifdef SDRAM_AUTO_PRE_EN
                        w_bank_q = w_bank;
`endif
                    end
                    3'd7: begin
                        w_cmd  = C_PRE;
                        w_ba   = w_bank;
                        w_addr = '0;
                    end
                    default: ;
                endcase
            end
            S_BURST: begin
                if (r_cnt != '0) w_cnt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_cmd = r_full ? C_NOP : C_BST;
`ifndef SDRAM_AUTO_PRE_EN
                    w_state = S_IDLE;
`endif
                end
`ifdef SDRAM_AUTO_PRE_EN
                if (r_cnt == '0) begin
                    if (r_wr) begin
                        w_state = S_TWR;
                        w_wait  = WT_W'(T_WR);
                    end else begin
                        w_state = S_APRE;
                        w_cmd   = C_PRE;
                        w_ba    = r_bank;
                        w_addr  = '0;
                    end
                end
`endif
            end
`ifdef SDRAM_AUTO_PRE_EN
            S_TWR: begin
                if (r_wait <= WT_W'(1)) begin
                    w_state = S_APRE;
                    w_cmd   = C_PRE;
                    w_ba    = r_bank;
                    w_addr  = '0;
                end else begin
                    w_wait = r_wait - WT_W'(1);
                end
            end
            S_APRE: begin
                w_state = S_TRP;
                w_wait  = WT_W'(T_RP);
            end
            S_TRP: begin
                if (r_wait <= WT_W'(1)) w_state = S_IDLE;
                else w_wait = r_wait - WT_W'(1);
            end
`endif
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cke   <= 1'b0;
            r_cmd   <= 4'b1111;
            r_ba    <= '1;
            r_addr  <= '1;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_full  <= 1'b0;
            r_rd_sr <= '0;
`ifdef SDRAM_AUTO_PRE_EN
            r_wait  <= '0;
            r_bank  <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_cke   <= 1'b1;
            r_cmd   <= w_cmd;
            r_ba    <= w_ba;
            r_addr  <= w_addr;
            r_cnt   <= w_cnt;
            r_wr    <= w_wr;
            r_full  <= w_full;
            r_rd_sr <= {r_rd_sr[CAS_LAT-2:0], w_xfer && !r_wr};
`ifdef SDRAM_AUTO_PRE_EN
            r_wait  <= w_wait;
            r_bank  <= w_bank_q;
`endif
        end
    end

    // cke doubles as the "out of reset" flag so ready stays low until the first edge
    assign op_ready   = r_cke && (r_state == S_IDLE);
    assign sdram_cke  = r_cke;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
    assign sdram_ba   = r_ba;
    assign sdram_addr = r_addr;
    assign wr_data_en = w_xfer && r_wr;
    assign rd_data_en = r_rd_sr[CAS_LAT-1];
endmodule

// File: tb/tb_sdram_cmd_gen.sv
// tb_sdram_cmd_gen: vector table, directed burst/reset sequences and a randomized timeline model.
// Adapts its expectations when SDRAM_AUTO_PRE_EN is defined.
module tb_sdram_cmd_gen;
    localparam int CL = 3, TWR = 2, TRP = 3;
    localparam int NC = 3000, MS = NC + 700;
`ifdef SDRAM_AUTO_PRE_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif
    localparam logic [3:0] NOP = 4'b0111, RD = 4'b0101, WR = 4'b0100, BST = 4'b0110, PRE = 4'b0010;

    logic        clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0;
    logic [2:0]  op_code = '0;
    logic [20:0] op_addr = '0;
    logic [8:0]  op_len = '0;
    logic        op_ready, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [10:0] sdram_addr;
    logic        wr_data_en, rd_data_en;
    logic [3:0]  cmd;
    int checks = 0, errors = 0;

    sdram_cmd_gen #(.BA_W(2), .ROW_W(11), .COL_W(8), .CAS_LAT(CL), .T_WR(TWR), .T_RP(TRP)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .op_addr(op_addr),
        .op_len(op_len), .op_ready(op_ready), .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
        .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .wr_data_en(wr_data_en), .rd_data_en(rd_data_en)
    );

    always #5 clk = ~clk;
    assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

    typedef struct {
        logic [2:0]  code;
        logic [20:0] addr;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [10:0] a;
        logic [10:0] mask;
    } vec_t;
    vec_t vt[8];

    logic [3:0]  m_cmd[MS];
    logic [1:0]  m_ba[MS];
    logic [10:0] m_addr[MS], m_mask[MS];
    logic        m_wr[MS], m_rd[MS], m_rdy[MS];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [20:0] obs(input logic [10:0] mask);
        return {sdram_cke, cmd, sdram_ba, sdram_addr & mask, wr_data_en, rd_data_en, op_ready};
    endfunction

    task automatic nxt;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [20:0] a, input logic [8:0] l);
        op_valid = v;
        op_code  = c;
        op_addr  = a;
        op_len   = l;
    endtask

    task automatic wait_idle;
        int n = 0;
        drive(1'b0, 3'd0, '0, '0);
        while (!op_ready && n < 400) begin
            nxt;
            n++;
        end
        chk("idle_timeout", {31'b0, op_ready}, 32'd1);
        repeat (CL + 2) nxt;
    endtask

    task automatic put(input int i, input logic [3:0] c, input logic [1:0] b, input logic [10:0] a, input logic [10:0] m);
        m_cmd[i]  = c;
        m_ba[i]   = b;
        m_addr[i] = a;
        m_mask[i] = m;
    endtask

    // Timeline model: an accepted request at cycle c paints its whole effect onto future cycles
    task automatic sched(input int c, input logic [2:0] code, input logic [20:0] a, input logic [8:0] len);
        int p = c + 1;
        int l, e;
        logic [1:0] bk = a[20:19];
        case (code)
            3'd1: put(p, PRE, 2'b11, 11'h400, 11'h400);
            3'd2: put(p, 4'b0001, 2'b11, 11'h7FF, 11'h7FF);
            3'd3: put(p, 4'b0000, 2'b00, 11'(CL * 16 + 7), 11'h7FF);
            3'd4: put(p, 4'b0011, bk, a[18:8], 11'h7FF);
            3'd7: put(p, PRE, bk, 11'h000, 11'h400);
            3'd5, 3'd6: begin
                l = (len == 0) ? 1 : int'(len);
                put(p, (code == 3'd5) ? RD : WR, bk, {3'b000, a[7:0]}, 11'h7FF);
                for (int k = 0; k < l; k++) begin
                    m_rdy[p+k] = 1'b0;
                    if (code == 3'd6) m_wr[p+k] = 1'b1;
                    else m_rd[p+k+CL] = 1'b1;
                end
                if (l != 256) put(p + l, BST, 2'b11, 11'h7FF, 11'h7FF);
                if (AP) begin
                    e = p + l + 1 + ((code == 3'd6) ? TWR : 0);
                    put(e, PRE, bk, 11'h000, 11'h400);
                    for (int k = p + l; k <= e + TRP; k++) m_rdy[k] = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{3'd0, 21'h1ABCDE, NOP, 2'd3, 11'h7FF, 11'h7FF};
        vt[1] = '{3'd1, 21'h012345, PRE, 2'd3, 11'h400, 11'h400};
        vt[2] = '{3'd2, 21'h0F0F0F, 4'b0001, 2'd3, 11'h7FF, 11'h7FF};
        vt[3] = '{3'd3, 21'h1FFFFF, 4'b0000, 2'd0, 11'h037, 11'h7FF};
        vt[4] = '{3'd4, {2'd2, 11'h155, 8'h00}, 4'b0011, 2'd2, 11'h155, 11'h7FF};
        vt[5] = '{3'd7, {2'd1, 11'h7FF, 8'hFF}, PRE, 2'd1, 11'h000, 11'h400};
        vt[6] = '{3'd4, {2'd3, 11'h7AA, 8'h12}, 4'b0011, 2'd3, 11'h7AA, 11'h7FF};
        vt[7] = '{3'd4, {2'd0, 11'h000, 8'hFF}, 4'b0011, 2'd0, 11'h000, 11'h7FF};

        repeat (3) nxt;
        chk("reset_state", obs(11'h7FF), {1'b0, 4'hF, 2'd3, 11'h7FF, 3'b000});
        rst_n = 1'b1;
        nxt;
        chk("reset_release", obs(11'h7FF), {1'b1, NOP, 2'd3, 11'h7FF, 3'b001});

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].code, vt[i].addr, 9'd1);
            nxt;
            drive(1'b0, 3'd0, '0, '0);
            chk($sformatf("vec%0d", i), obs(vt[i].mask), {1'b1, vt[i].cmd, vt[i].ba, vt[i].a & vt[i].mask, 3'b001});
        end
        nxt;
        chk("vec_back_to_nop", obs(11'h7FF), {1'b1, NOP, 2'd3, 11'h7FF, 3'b001});

        // WR len 4, with a request pushed at N and N+1 that must be dropped
        drive(1'b1, 3'd6, {2'd1, 11'h0, 8'h10}, 9'd4);
        for (int k = 0; k <= 5; k++) begin
            nxt;
            if (k < 2) drive(1'b1, 3'd4, {2'd2, 11'h3C3, 8'h0}, 9'd1);
            else drive(1'b0, 3'd0, '0, '0);
            chk($sformatf("wr4_cmd k%0d", k), {28'b0, cmd}, {28'b0, (k == 0) ? WR : (k == 4) ? BST : NOP});
            chk($sformatf("wr4_en k%0d", k), {31'b0, wr_data_en}, {31'b0, k < 4});
            if (k == 0) chk("wr4_addr", {sdram_ba, sdram_addr}, {2'd1, 11'h010});
            if (k <= 4) chk($sformatf("wr4_rdy k%0d", k), {31'b0, op_ready}, {31'b0, k == 4 && !AP});
        end
        wait_idle;

        // Full-page read: no BST, read strobe for 256 cycles after CAS latency
        drive(1'b1, 3'd5, {2'd3, 11'h0, 8'h00}, 9'h100);
        for (int k = 0; k <= 260; k++) begin
            nxt;
            drive(1'b0, 3'd0, '0, '0);
            if (!(AP && k == 257)) chk($sformatf("rd256_cmd k%0d", k), {28'b0, cmd}, {28'b0, (k == 0) ? RD : NOP});
            chk($sformatf("rd256_en k%0d", k), {31'b0, rd_data_en}, {31'b0, k >= CL && k <= CL + 255});
            if (k == 255 || k == 256) chk($sformatf("rd256_rdy k%0d", k), {31'b0, op_ready}, {31'b0, k == 256 && !AP});
        end
        wait_idle;

        // Reset asserted at N+2 of a len 8 read
        drive(1'b1, 3'd5, {2'd2, 11'h0, 8'h40}, 9'd8);
        nxt;
        drive(1'b0, 3'd0, '0, '0);
        chk("rst_mid_rd_cmd", {28'b0, cmd}, {28'b0, RD});
        nxt;
        nxt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_now", obs(11'h7FF), {1'b0, 4'hF, 2'd3, 11'h7FF, 3'b000});
        for (int k = 0; k < 3; k++) begin
            nxt;
            chk($sformatf("rst_mid_hold k%0d", k), obs(11'h7FF), {1'b0, 4'hF, 2'd3, 11'h7FF, 3'b000});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            nxt;
            chk($sformatf("rst_mid_after k%0d", k), obs(11'h7FF), {1'b1, NOP, 2'd3, 11'h7FF, 3'b001});
        end

`ifdef SDRAM_AUTO_PRE_EN
        // Auto-precharge after a len 2 write
        drive(1'b1, 3'd6, {2'd2, 11'h0, 8'h05}, 9'd2);
        for (int k = 0; k <= 9; k++) begin
            nxt;
            drive(1'b0, 3'd0, '0, '0);
            chk($sformatf("ap_cmd k%0d", k), {28'b0, cmd}, {28'b0, (k == 0) ? WR : (k == 2) ? BST : (k == 5) ? PRE : NOP});
            chk($sformatf("ap_rdy k%0d", k), {31'b0, op_ready}, {31'b0, k == 9});
            if (k == 5) chk("ap_pre_bank", {sdram_ba, sdram_addr[10]}, {2'd2, 1'b0});
        end
        wait_idle;
`endif

        for (int i = 0; i < MS; i++) begin
            put(i, NOP, 2'b11, 11'h7FF, 11'h7FF);
            m_wr[i]  = 1'b0;
            m_rd[i]  = 1'b0;
            m_rdy[i] = 1'b1;
        end
        for (int c = 0; c < NC; c++) begin
            logic [2:0]  rc;
            logic [20:0] ra;
            logic [8:0]  rl;
            int sel;
            logic rv;
            nxt;
            chk($sformatf("rand c%0d", c), obs(m_mask[c]),
                {1'b1, m_cmd[c], m_ba[c], m_addr[c] & m_mask[c], m_wr[c], m_rd[c], m_rdy[c]});
            rv  = ($urandom_range(0, 3) != 0);
            rc  = 3'($urandom_range(0, 7));
            ra  = 21'($urandom);
            sel = $urandom_range(0, 39);
            rl  = (sel == 0) ? 9'h100 : (sel == 1) ? 9'($urandom_range(0, 256)) : 9'($urandom_range(0, 9));
            drive(rv, rc, ra, rl);
            if (rv && m_rdy[c]) sched(c, rc, ra, rl);
        end
        drive(1'b0, 3'd0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
